// File: rtl/collision_ctrl_pkg.sv
// rtl/collision_ctrl_pkg.sv - shared state encoding, BCD width and BCD helpers for the goose game
package collision_ctrl_pkg;

  localparam int BCD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  // Ripple the carry up from the LSD; a digit of 9 rolls to 0 and passes the carry on.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // The first differing digit, scanning from the MSD, decides the magnitude order.
  function automatic logic bcd_gt(input logic [BCD_W-1:0] a, input logic [BCD_W-1:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = BCD_W / 4 - 1; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        gt      = a[4*i +: 4] > b[4*i +: 4];
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/collision_ctrl_if.sv
// rtl/collision_ctrl_if.sv - pixel/button inputs and game-state outputs of the collision controller
interface collision_ctrl_if;
  import collision_ctrl_pkg::*;

  logic             frame_end;
  logic             video_on;
  logic             goose;
  logic             bean;
  logic             start_btn;
  logic             check_hit;
  logic             game_reset;
  logic             running;
  logic             game_over;
  logic [BCD_W-1:0] score;
  logic [BCD_W-1:0] hi_score;

  modport master (
    output frame_end, video_on, goose, bean, start_btn,
    input  check_hit, game_reset, running, game_over, score, hi_score
  );

  modport slave (
    input  frame_end, video_on, goose, bean, start_btn,
    output check_hit, game_reset, running, game_over, score, hi_score
  );

endinterface

// File: rtl/collision_ctrl_bcd_counter4.sv
// rtl/collision_ctrl_bcd_counter4.sv - 4-digit BCD counter that sticks at 9999
module bcd_counter4
  import collision_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [BCD_W-1:0] o_q
);

  localparam logic [BCD_W-1:0] LP_MAX = 16'h9999;

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_q <= '0;
    end else if (i_inc && (r_q != LP_MAX)) begin
      r_q <= bcd_inc(r_q);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/collision_ctrl.sv
// rtl/collision_ctrl.sv - goose/obstacle overlap detector, game FSM, BCD score and high score
module collision_ctrl
  import collision_ctrl_pkg::*;
#(
  parameter int HIT_MIN_PIX     = 4,
  parameter int HIT_HOLD_FRAMES = 30,
  parameter int SCORE_DIV       = 6
) (
  input  logic           i_clk,
  input  logic           i_reset,
  collision_ctrl_if.slave bus
);

  localparam logic [7:0] LP_HIT_MIN  = 8'(HIT_MIN_PIX);
  localparam logic [7:0] LP_HOLD_MAX = 8'(HIT_HOLD_FRAMES - 1);
  localparam logic [7:0] LP_DIV_MAX  = 8'(SCORE_DIV - 1);

  state_t           r_state;
  logic             r_start_q;
  logic [7:0]       r_ov_cnt;
  logic [7:0]       r_div_cnt;
  logic [7:0]       r_hold_cnt;
  logic             r_check_hit;
  logic             r_game_reset;
  logic             r_running;
  logic             r_game_over;
  logic [BCD_W-1:0] r_hi_score;

  logic             w_start_rise;
  logic             w_restart;
  logic             w_ov_pix;
  logic [7:0]       w_ov_sum;
  logic             w_hit;
  logic             w_score_clear;
  logic             w_score_inc;
  logic [BCD_W-1:0] w_score;

  assign w_start_rise = bus.start_btn & ~r_start_q;
  assign w_restart    = w_start_rise & ((r_state == ST_IDLE) | (r_state == ST_OVER));
  assign w_ov_pix     = bus.video_on & bus.goose & bus.bean;

  // The frame_end cycle's own pixel still counts towards this frame's total.
  assign w_ov_sum = (w_ov_pix && (r_ov_cnt != 8'hFF)) ? r_ov_cnt + 8'd1 : r_ov_cnt;
  assign w_hit    = (r_state == ST_RUN) & bus.frame_end & (w_ov_sum >= LP_HIT_MIN);

  assign w_score_clear = i_reset | w_restart;
  assign w_score_inc   = (r_state == ST_RUN) & bus.frame_end & ~w_hit & (r_div_cnt == LP_DIV_MAX);

  bcd_counter4 u_score (
    .i_clk   (i_clk),
    .i_clear (w_score_clear),
    .i_inc   (w_score_inc),
    .o_q     (w_score)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_start_q    <= 1'b0;
      r_ov_cnt     <= '0;
      r_div_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_check_hit  <= 1'b0;
      r_game_reset <= 1'b0;
      r_running    <= 1'b0;
      r_game_over  <= 1'b0;
      r_hi_score   <= '0;
    end else begin
      r_start_q    <= bus.start_btn;
      r_game_reset <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start_rise) begin
            r_state      <= ST_RUN;
            r_game_reset <= 1'b1;
            r_running    <= 1'b1;
            r_game_over  <= 1'b0;
            r_check_hit  <= 1'b0;
            r_ov_cnt     <= '0;
            r_div_cnt    <= '0;
            r_hold_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (bus.frame_end) begin
            r_ov_cnt <= '0;
            if (w_hit) begin
              r_state     <= ST_HIT;
              r_hold_cnt  <= '0;
              r_check_hit <= 1'b1;
              r_running   <= 1'b0;
            end else if (r_div_cnt == LP_DIV_MAX) begin
              r_div_cnt <= '0;
            end else begin
              r_div_cnt <= r_div_cnt + 8'd1;
            end
          end else begin
            r_ov_cnt <= w_ov_sum;
          end
        end
        ST_HIT: begin
          if (bus.frame_end) begin
            if (r_hold_cnt == LP_HOLD_MAX) begin
              r_state     <= ST_OVER;
              r_game_over <= 1'b1;
              if (bcd_gt(w_score, r_hi_score)) begin
                r_hi_score <= w_score;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.check_hit  = r_check_hit;
  assign bus.game_reset = r_game_reset;
  assign bus.running    = r_running;
  assign bus.game_over  = r_game_over;
  assign bus.score      = w_score;
  assign bus.hi_score   = r_hi_score;

endmodule

// File: doc/collision_ctrl.md
# collision_ctrl

Game-state controller directly downstream of the obstacle renderer. It watches the per-pixel `bean` flag together with the goose sprite flag and detects overlap during active video. It drives `check_hit`, which freezes obstacle scrolling, and `game_reset`, which restores obstacle positions. It also keeps a BCD score and high score for the HUD.

## Interface
Parameters:
- HIT_MIN_PIX, 4: overlapping pixels needed in one frame to count as a hit (range 1..255).
- HIT_HOLD_FRAMES, 30: frames spent in HIT before GAME_OVER (range 1..255).
- SCORE_DIV, 6: RUN frames per score increment (range 1..255).

Ports:
- clk, in, 1: system/pixel clock.
- reset, in, 1: synchronous, active-high; clears everything, including hi_score.
- frame_end, in, 1: one-cycle pulse once per frame, after the last active pixel.
- video_on, in, 1: current pixel is in the visible area.
- goose, in, 1: current pixel belongs to the goose sprite.
- bean, in, 1: current pixel belongs to an obstacle (renderer output).
- start_btn, in, 1: start/restart button, already synchronised and debounced.
- check_hit, out, 1: freeze request to the obstacle renderer; level signal.
- game_reset, out, 1: one-cycle pulse that restarts the obstacle field.
- running, out, 1: high in RUN.
- game_over, out, 1: high in GAME_OVER.
- score, out, 16: 4-digit BCD; [15:12] is the thousands digit.
- hi_score, out, 16: 4-digit BCD best score.

## Operation
- States: IDLE, RUN, HIT, GAME_OVER. Encoding is 2-bit, defined in the shared header.
- Start detection: `start_q` registers `start_btn`. `start_rise = start_btn & ~start_q`.
- IDLE:
  - On `start_rise`, go to RUN, pulse `game_reset`, clear score and all counters.
- RUN, overlap counting:
  - `ov_cnt` is 8 bits and saturates at 255.
  - It increments on every cycle where `video_on & goose & bean`.
- RUN, on frame_end:
  - If `ov_cnt` (including an overlap in the frame_end cycle itself) is at least HIT_MIN_PIX, go to HIT and set `hold_cnt=0`.
  - Otherwise, advance `div_cnt`. When `div_cnt` reaches SCORE_DIV-1, reset it to 0 and increment score.
  - `ov_cnt` clears at every frame_end.
- Score arithmetic:
  - BCD increment with per-digit carry.
  - Saturates at 9999 and never wraps to 0000.
- HIT:
  - `check_hit=1`.
  - Score and `div_cnt` are frozen. `start_rise` is ignored.
  - Each frame_end increments `hold_cnt`.
  - When `hold_cnt` reaches HIT_HOLD_FRAMES-1 at a frame_end, go to GAME_OVER.
  - If score > hi_score (BCD magnitude compare, digit-wise from MSD), copy score into hi_score on that same transition.
- GAME_OVER:
  - `check_hit` stays 1 and score stays displayed.
  - On `start_rise`, go to RUN, pulse `game_reset`, clear score, `ov_cnt`, `div_cnt` and `hold_cnt`.
  - hi_score is kept.
- Boundary rules:
  - Overlap pixels while `video_on=0` are ignored.
  - A `start_rise` in RUN or HIT has no effect.
  - A button held through the transition into GAME_OVER does not restart the game; a new rising edge is required.
  - `reset` overrides every other input in the same cycle.

## Timing
- All outputs are registered.
- Values after reset:
  - state IDLE.
  - check_hit=0, game_reset=0, running=0, game_over=0.
  - score=0x0000, hi_score=0x0000.
  - start_q=0, all counters 0.
- `game_reset` is high for exactly the one cycle after the cycle in which `start_rise` is sampled in IDLE or GAME_OVER. `running` rises in that same cycle.
- `check_hit` rises on the cycle after the frame_end that evaluates the hit. Because of this one-cycle latency, the renderer stops scrolling from the next frame onward.
- `check_hit` falls in the same cycle that `game_reset` pulses.
- The score update is visible the cycle after the qualifying frame_end.
- hi_score is updated in the same cycle that `game_over` rises.

## Structure
- Shared header `game_defs.vh` holds:
  - state encodings `ST_IDLE=0`, `ST_RUN=1`, `ST_HIT=2`, `ST_OVER=3`;
  - the BCD width constant (16).
- The renderer and HUD include the same header.
- Sub-module `bcd_counter4`:
  - ports: clk, clear, inc, q[15:0];
  - saturating 4-digit BCD counter;
  - instantiated for score.
- The hi_score compare/load stays in the top level.

## Test plan
- Reset, then start pulse: `game_reset` high for 1 cycle, `running=1`, score=0x0000; after 12 clean frame_ends, score=0x0002 (SCORE_DIV=6).
- In RUN, drive 3 overlap pixels in one frame, then frame_end → no hit. Drive 4 overlap pixels in the next frame → `check_hit=1` one cycle after frame_end, and score stops incrementing.
- Overlap pixels with `video_on=0` (10 pixels) → no hit. A single overlap in the frame_end cycle that completes a count of 4 → hit.
- After a hit with score 0x0007, run 30 frame_ends → `game_over=1`, hi_score=0x0007. Next game ends at 0x0003 → hi_score remains 0x0007.
- Preload to 0x9998 and give 12 increments → score holds 0x9999. A 0x0999 → 0x1000 carry is correct.
- Start held high across entry to GAME_OVER → no restart until the button is released and pressed again. `reset` asserted mid-HIT → IDLE, hi_score=0x0000, `check_hit=0` the next cycle.
